// File: rtl/board_checker.sv
// 3x3 board store with a sequential 8-line win/draw scan after each accepted move.
// Define BOARD_CHECKER_WINLINE_EN to add the winLine output reporting the winning line index.
module board_checker #(
  parameter int ADDR_W    = 4,
  parameter int LAST_CELL = 8,
  parameter int CELL_W    = 2
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              newGame,
  input  logic              cellWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CELL_W-1:0] cellState,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [CELL_W-1:0] rdState,
  output logic              busy,
  output logic              writeReject,
  output logic              gameIsDone,
  output logic [CELL_W-1:0] winner,
  output logic [3:0]        moveCount
`ifdef BOARD_CHECKER_WINLINE_EN
  ,
  output logic [2:0]        winLine
`endif
);

  localparam int NCELLS = LAST_CELL + 1;
  localparam logic [CELL_W-1:0] EMPTY = CELL_W'(0);
  localparam logic [CELL_W-1:0] X     = CELL_W'(2);
  localparam logic [CELL_W-1:0] O     = CELL_W'(3);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CELL_W-1:0] board_q [NCELLS];
  logic [CELL_W-1:0] board_d [NCELLS];
  logic [2:0]        line_idx_q, line_idx_d;
  logic [3:0]        move_count_q, move_count_d;
  logic              write_reject_q, write_reject_d;
  logic              game_done_q, game_done_d;
  logic [CELL_W-1:0] winner_q, winner_d;
  logic              match_q, match_d;
  logic [CELL_W-1:0] owner_q, owner_d;
`ifdef BOARD_CHECKER_WINLINE_EN
  logic [2:0]        win_line_q, win_line_d;
`endif

  logic [CELL_W-1:0] addr_cell;
  logic [CELL_W-1:0] line_a, line_b, line_c;
  logic              line_hit;
  logic              write_ok;

  always_comb begin
    addr_cell = EMPTY;
    rdState   = EMPTY;
    for (int i = 0; i < NCELLS; i++) begin
      if (addr == ADDR_W'(i))   addr_cell = board_q[i];
      if (rdAddr == ADDR_W'(i)) rdState   = board_q[i];
    end
  end

  assign write_ok = (addr <= ADDR_W'(LAST_CELL)) &&
                    ((cellState == X) || (cellState == O)) &&
                    (addr_cell == EMPTY);

  // Rows, then columns, then the two diagonals.
  always_comb begin
    line_a = EMPTY;
    line_b = EMPTY;
    line_c = EMPTY;
    case (line_idx_q)
      3'd0:    begin line_a = board_q[0]; line_b = board_q[1]; line_c = board_q[2]; end
      3'd1:    begin line_a = board_q[3]; line_b = board_q[4]; line_c = board_q[5]; end
      3'd2:    begin line_a = board_q[6]; line_b = board_q[7]; line_c = board_q[8]; end
      3'd3:    begin line_a = board_q[0]; line_b = board_q[3]; line_c = board_q[6]; end
      3'd4:    begin line_a = board_q[1]; line_b = board_q[4]; line_c = board_q[7]; end
      3'd5:    begin line_a = board_q[2]; line_b = board_q[5]; line_c = board_q[8]; end
      3'd6:    begin line_a = board_q[0]; line_b = board_q[4]; line_c = board_q[8]; end
      default: begin line_a = board_q[2]; line_b = board_q[4]; line_c = board_q[6]; end
    endcase
  end

  assign line_hit = (line_a != EMPTY) && (line_a == line_b) && (line_b == line_c);

  always_comb begin
    state_d        = state_q;
    board_d        = board_q;
    line_idx_d     = line_idx_q;
    move_count_d   = move_count_q;
    write_reject_d = 1'b0;
    game_done_d    = game_done_q;
    winner_d       = winner_q;
    match_d        = match_q;
    owner_d        = owner_q;
`ifdef BOARD_CHECKER_WINLINE_EN
    win_line_d     = win_line_q;
`endif

    if (newGame) begin
      // A write coinciding with newGame is silently dropped.
      state_d      = IDLE;
      for (int i = 0; i < NCELLS; i++) board_d[i] = EMPTY;
      line_idx_d   = 3'd0;
      move_count_d = 4'd0;
      game_done_d  = 1'b0;
      winner_d     = EMPTY;
      match_d      = 1'b0;
      owner_d      = EMPTY;
`ifdef BOARD_CHECKER_WINLINE_EN
      win_line_d   = 3'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cellWrite) begin
            if (write_ok) begin
              for (int i = 0; i < NCELLS; i++) begin
                if (addr == ADDR_W'(i)) board_d[i] = cellState;
              end
              move_count_d = (move_count_q == 4'd9) ? 4'd9 : move_count_q + 4'd1;
              state_d      = SCAN;
              line_idx_d   = 3'd0;
              match_d      = 1'b0;
              owner_d      = EMPTY;
            end else begin
              write_reject_d = 1'b1;
            end
          end
        end
        SCAN: begin
          write_reject_d = cellWrite;
          if (line_hit && !match_q) begin
            match_d = 1'b1;
            owner_d = line_a;
`ifdef BOARD_CHECKER_WINLINE_EN
            win_line_d = line_idx_q;
`endif
          end
          // The scan never exits early; the verdict is taken on the eighth line.
          if (line_idx_q == 3'd7) begin
            if (match_d) begin
              state_d     = DONE;
              game_done_d = 1'b1;
              winner_d    = owner_d;
            end else if (move_count_q == 4'd9) begin
              state_d     = DONE;
              game_done_d = 1'b1;
              winner_d    = EMPTY;
            end else begin
              state_d     = IDLE;
            end
          end else begin
            line_idx_d = line_idx_q + 3'd1;
          end
        end
        default: begin
          write_reject_d = cellWrite;
        end
      endcase
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      for (int i = 0; i < NCELLS; i++) board_q[i] <= EMPTY;
      line_idx_q     <= 3'd0;
      move_count_q   <= 4'd0;
      write_reject_q <= 1'b0;
      game_done_q    <= 1'b0;
      winner_q       <= EMPTY;
      match_q        <= 1'b0;
      owner_q        <= EMPTY;
`ifdef BOARD_CHECKER_WINLINE_EN
      win_line_q     <= 3'd0;
`endif
    end else begin
      state_q        <= state_d;
      board_q        <= board_d;
      line_idx_q     <= line_idx_d;
      move_count_q   <= move_count_d;
      write_reject_q <= write_reject_d;
      game_done_q    <= game_done_d;
      winner_q       <= winner_d;
      match_q        <= match_d;
      owner_q        <= owner_d;
`ifdef BOARD_CHECKER_WINLINE_EN
      win_line_q     <= win_line_d;
`endif
    end
  end

  assign busy        = (state_q == SCAN);
  assign writeReject = write_reject_q;
  assign gameIsDone  = game_done_q;
  assign winner      = winner_q;
  assign moveCount   = move_count_q;
`ifdef BOARD_CHECKER_WINLINE_EN
  assign winLine     = (game_done_q && (winner_q != EMPTY)) ? win_line_q : 3'd0;
`endif

endmodule

// File: tb/tb_board_checker.sv
// Bench for board_checker: directed game scenarios plus random games against a rule-level model.
// Also checks winLine when BOARD_CHECKER_WINLINE_EN is defined.
module tb_board_checker;
  logic       ph1 = 1'b0;
  logic       reset, newGame, cellWrite;
  logic [3:0] addr, rdAddr;
  logic [1:0] cellState, rdState, winner;
  logic       busy, writeReject, gameIsDone;
  logic [3:0] moveCount;
`ifdef BOARD_CHECKER_WINLINE_EN
  logic [2:0] winLine;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: board contents and game outcome derived from the rules.
  logic [1:0] mboard [9];
  int         mcount;
  bit         mdone;
  logic [1:0] mwinner;
  int         mline;
  int         lines_tab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                   '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  always #10 ph1 = ~ph1;

  board_checker dut (
    .ph1(ph1), .reset(reset), .newGame(newGame), .cellWrite(cellWrite),
    .addr(addr), .cellState(cellState), .rdAddr(rdAddr), .rdState(rdState),
    .busy(busy), .writeReject(writeReject), .gameIsDone(gameIsDone),
    .winner(winner), .moveCount(moveCount)
`ifdef BOARD_CHECKER_WINLINE_EN
    , .winLine(winLine)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) mboard[i] = 2'b00;
    mcount = 0; mdone = 0; mwinner = 2'b00; mline = 0;
  endtask

  // First complete line in scan order decides the winner; a full board otherwise draws.
  task automatic model_resolve();
    for (int l = 7; l >= 0; l--) begin
      if (mboard[lines_tab[l][0]] != 2'b00 &&
          mboard[lines_tab[l][0]] == mboard[lines_tab[l][1]] &&
          mboard[lines_tab[l][1]] == mboard[lines_tab[l][2]]) begin
        mdone = 1; mwinner = mboard[lines_tab[l][0]]; mline = l;
      end
    end
    if (!mdone && mcount == 9) begin
      mdone = 1; mwinner = 2'b00;
    end
  endtask

  task automatic check_status(input string tag, input bit exp_busy);
    chk({tag, ".busy"}, busy, exp_busy);
    chk({tag, ".done"}, gameIsDone, mdone);
    chk({tag, ".winner"}, winner, mwinner);
    chk({tag, ".moves"}, moveCount, mcount);
`ifdef BOARD_CHECKER_WINLINE_EN
    chk({tag, ".winLine"}, winLine, (mdone && mwinner != 2'b00) ? mline : 0);
`endif
  endtask

  task automatic check_board(input string tag);
    for (int i = 0; i < 9; i++) begin
      rdAddr = 4'(i);
      #1;
      chk($sformatf("%s.cell%0d", tag, i), rdState, mboard[i]);
    end
  endtask

  task automatic do_new_game(input string tag);
    newGame = 1'b1;
    @(posedge ph1); #1;
    newGame = 1'b0;
    model_clear();
    check_status(tag, 1'b0);
    chk({tag, ".rej"}, writeReject, 1'b0);
  endtask

  task automatic play_move(input string tag, input int a, input logic [1:0] s);
    bit acc;
    acc = !mdone && a <= 8 && (s == 2'b10 || s == 2'b11);
    if (acc) acc = (mboard[a] == 2'b00);
    addr = 4'(a); cellState = s; cellWrite = 1'b1;
    @(posedge ph1); #1;
    cellWrite = 1'b0;
    chk({tag, ".rej"}, writeReject, !acc);
    if (acc) begin
      mboard[a] = s;
      mcount++;
      chk({tag, ".busy_k"}, busy, 1'b1);
      repeat (7) @(posedge ph1);
      #1;
      chk({tag, ".busy_k7"}, busy, 1'b1);
      @(posedge ph1); #1;
      model_resolve();
      check_status({tag, ".k8"}, 1'b0);
    end else begin
      check_status({tag, ".rejstat"}, 1'b0);
      @(posedge ph1); #1;
      chk({tag, ".rej_end"}, writeReject, 1'b0);
    end
    check_board(tag);
    $display("move %s: addr=%0d state=%b accepted=%0d done=%0d winner=%b moves=%0d",
             tag, a, s, acc, gameIsDone, winner, moveCount);
  endtask

  initial begin
    int xs [5];
    int os [4];
    reset = 1'b0; newGame = 1'b0; cellWrite = 1'b0;
    addr = '0; cellState = '0; rdAddr = '0;
    model_clear();
    #5;
    check_status("reset", 1'b0);
    chk("reset.rej", writeReject, 1'b0);
    check_board("reset");
    reset = 1'b1;
    @(posedge ph1); #1;

    // Row 0 win for X, with an occupied-cell write attempted mid-game.
    play_move("g1x0", 0, 2'b10);
    play_move("g1o3", 3, 2'b11);
    play_move("g1x1", 1, 2'b10);
    play_move("g1o4", 4, 2'b11);
    play_move("g1occ", 4, 2'b11);
    play_move("g1x2", 2, 2'b10);
    chk("g1.winner_x", winner, 2'b10);
    play_move("g1after", 5, 2'b11);

    // Out-of-range address and illegal state, then out-of-range read.
    do_new_game("ng2");
    play_move("badaddr", 9, 2'b10);
    play_move("badstate", 0, 2'b01);
    rdAddr = 4'd12; #1;
    chk("rd12", rdState, 2'b00);

    // Draw game.
    xs = '{0, 2, 3, 7, 8};
    os = '{1, 4, 5, 6};
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) play_move($sformatf("draw%0d", i), xs[i/2], 2'b10);
      else            play_move($sformatf("draw%0d", i), os[i/2], 2'b11);
    end
    chk("draw.done", gameIsDone, 1'b1);
    play_move("draw.extra", 0, 2'b11);

    // Write during scan at edge k+3.
    do_new_game("ng3");
    addr = 4'd0; cellState = 2'b10; cellWrite = 1'b1;
    @(posedge ph1); #1;
    cellWrite = 1'b0;
    mboard[0] = 2'b10; mcount = 1;
    chk("scanwr.busy_k", busy, 1'b1);
    repeat (2) @(posedge ph1);
    #1;
    addr = 4'd1; cellState = 2'b11; cellWrite = 1'b1;
    @(posedge ph1); #1;
    cellWrite = 1'b0;
    chk("scanwr.rej_k3", writeReject, 1'b1);
    chk("scanwr.busy_k3", busy, 1'b1);
    repeat (5) @(posedge ph1);
    #1;
    check_status("scanwr.k8", 1'b0);
    check_board("scanwr");
    $display("scan-write: rejected mid-scan, moves=%0d", moveCount);

    // newGame with a simultaneous write at edge k+4.
    addr = 4'd4; cellState = 2'b11; cellWrite = 1'b1;
    @(posedge ph1); #1;
    cellWrite = 1'b0;
    repeat (3) @(posedge ph1);
    #1;
    newGame = 1'b1; cellWrite = 1'b1; addr = 4'd0; cellState = 2'b10;
    @(posedge ph1); #1;
    newGame = 1'b0; cellWrite = 1'b0;
    model_clear();
    check_status("ngscan", 1'b0);
    chk("ngscan.rej", writeReject, 1'b0);
    check_board("ngscan");
    repeat (8) @(posedge ph1);
    #1;
    check_status("ngscan.later", 1'b0);
    $display("newGame mid-scan: busy=%0d moves=%0d", busy, moveCount);

    // Reset pulled low mid-scan, then a normal move after release.
    addr = 4'd0; cellState = 2'b10; cellWrite = 1'b1;
    @(posedge ph1); #1;
    cellWrite = 1'b0;
    repeat (2) @(posedge ph1);
    #5;
    reset = 1'b0;
    #1;
    model_clear();
    check_status("rstscan", 1'b0);
    chk("rstscan.rej", writeReject, 1'b0);
    rdAddr = 4'd0; #1;
    chk("rstscan.cell0", rdState, 2'b00);
    #2;
    reset = 1'b1;
    @(posedge ph1); #1;
    play_move("postrst", 0, 2'b10);
    $display("reset mid-scan: cleared and recovered");

    // Random games.
    for (int g = 0; g < 20; g++) begin
      do_new_game($sformatf("rg%0d", g));
      for (int m = 0; m < 16 && !mdone; m++) begin
        int a, r;
        logic [1:0] s;
        a = $urandom_range(0, 10);
        r = $urandom_range(0, 9);
        if (r == 0)      s = 2'b01;
        else if (r == 1) s = 2'b00;
        else             s = (mcount % 2 == 0) ? 2'b10 : 2'b11;
        play_move($sformatf("rg%0d_m%0d", g, m), a, s);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
